// File: rtl/eq_coeff_loader.sv
// eq_coeff_loader
// Loads biquad coefficient sets from a host word stream into a shadow bank.
// On commit, the whole shadow bank is copied into the active bank on the next
// sample boundary, so every stage switches coefficients on the same sample.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_valid     host word valid
//   cfg_data      host word (header or coefficient)
//   cfg_ready     loader can accept a word (low only while waiting to apply)
//   sample_tick   one-cycle strobe at a filter-chain sample boundary
//   coeff_bus     active coefficients; stage s at [s*5*W +: 5*W], lowest word
//                 first: coeff_in_1, coeff_in_2, coeff_in_3, coeff_out_1, coeff_out_2
//   busy          FSM is not in IDLE
//   apply_done    one-cycle pulse after an active-bank update
//   err           sticky protocol error, cleared only by reset
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a header word
// LOAD       | collecting 5 coefficient words for the latched stage
// SKIP       | discarding 5 words after a LOAD to an out-of-range stage
// WAIT_APPLY | commit pending; copy shadow to active on next sample_tick
module eq_coeff_loader #(
    parameter int                      DATA_BIT_NUM = 16,
    parameter int                      NUM_STAGES   = 5,
    parameter logic [DATA_BIT_NUM-1:0] UNITY        = 16'h4000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    input  logic [DATA_BIT_NUM-1:0]            cfg_data,
    output logic                               cfg_ready,
    input  logic                               sample_tick,
    output logic [NUM_STAGES*5*DATA_BIT_NUM-1:0] coeff_bus,
    output logic                               busy,
    output logic                               apply_done,
    output logic                               err
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] LOAD       = 2'd1;
    localparam logic [1:0] SKIP       = 2'd2;
    localparam logic [1:0] WAIT_APPLY = 2'd3;

    localparam logic [3:0] SYNC_WORD = 4'hA;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_COMMIT = 4'd2;

    logic [1:0]              r_state;
    logic [2:0]              r_cnt;
    logic [3:0]              r_stage;
    logic                    r_apply_done;
    logic                    r_err;
    logic [DATA_BIT_NUM-1:0] r_staging [5];
    logic [DATA_BIT_NUM-1:0] r_shadow  [NUM_STAGES][5];
    logic [DATA_BIT_NUM-1:0] r_active  [NUM_STAGES][5];

    logic       w_accept;
    logic       w_sync_ok;
    logic [3:0] w_opcode;
    logic [3:0] w_index;
    logic       w_index_ok;
    logic       w_unused;

    assign cfg_ready  = (r_state != WAIT_APPLY);
    assign busy       = (r_state != IDLE);
    assign apply_done = r_apply_done;
    assign err        = r_err;

    assign w_accept   = cfg_valid && cfg_ready;
    assign w_sync_ok  = (cfg_data[15:12] == SYNC_WORD);
    assign w_opcode   = cfg_data[11:8];
    assign w_index    = cfg_data[3:0];
    assign w_index_ok = ({28'd0, w_index} < 32'(NUM_STAGES));
    // Reserved header bits carry no meaning.
    assign w_unused   = ^cfg_data[7:4];

    always_comb begin
        coeff_bus = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int k = 0; k < 5; k++) begin
                coeff_bus[(s*5+k)*DATA_BIT_NUM +: DATA_BIT_NUM] = r_active[s][k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_stage      <= '0;
            r_apply_done <= 1'b0;
            r_err        <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                r_staging[k] <= '0;
            end
            for (int s = 0; s < NUM_STAGES; s++) begin
                for (int k = 0; k < 5; k++) begin
                    r_shadow[s][k] <= (k == 0) ? UNITY : '0;
                    r_active[s][k] <= (k == 0) ? UNITY : '0;
                end
            end
        end else begin
            r_apply_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_sync_ok) begin
                            r_err <= 1'b1;
                        end else if (w_opcode == OP_LOAD) begin
                            r_cnt <= '0;
                            if (w_index_ok) begin
                                r_stage <= w_index;
                                r_state <= LOAD;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= SKIP;
                            end
                        end else if (w_opcode == OP_COMMIT) begin
                            r_state <= WAIT_APPLY;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_staging[r_cnt] <= cfg_data;
                        if (r_cnt == 3'd4) begin
                            // Fifth word comes straight from the bus so the whole
                            // set lands in the shadow bank on this edge.
                            for (int s = 0; s < NUM_STAGES; s++) begin
                                if (r_stage == 4'(s)) begin
                                    for (int k = 0; k < 4; k++) begin
                                        r_shadow[s][k] <= r_staging[k];
                                    end
                                    r_shadow[s][4] <= cfg_data;
                                end
                            end
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                SKIP: begin
                    if (w_accept) begin
                        if (r_cnt == 3'd4) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                WAIT_APPLY: begin
                    if (sample_tick) begin
                        for (int s = 0; s < NUM_STAGES; s++) begin
                            for (int k = 0; k < 5; k++) begin
                                r_active[s][k] <= r_shadow[s][k];
                            end
                        end
                        r_apply_done <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_coeff_loader.sv
// tb_eq_coeff_loader
// Directed bench for eq_coeff_loader: header parsing, stage loads, commit
// timing against sample_tick, error handling and asynchronous reset.
module tb_eq_coeff_loader;

    localparam int W  = 16;
    localparam int NS = 5;
    localparam logic [79:0] PASS = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid;
    logic [W-1:0]    cfg_data;
    logic            cfg_ready;
    logic            sample_tick;
    logic [NS*5*W-1:0] coeff_bus;
    logic            busy;
    logic            apply_done;
    logic            err;

    int errors = 0;
    int checks = 0;

    eq_coeff_loader #(.DATA_BIT_NUM(W), .NUM_STAGES(NS), .UNITY(16'h4000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .sample_tick (sample_tick),
        .coeff_bus   (coeff_bus),
        .busy        (busy),
        .apply_done  (apply_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] stage(input int s);
        return coeff_bus[s*80 +: 80];
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one word for a single edge; all callers run while ready is high.
    task automatic send(input logic [W-1:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [79:0] st0, st2, st3;

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        sample_tick = 1'b0;
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        for (int s = 0; s < NS; s++) chk($sformatf("rst_stage%0d", s), stage(s), PASS);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_apply", apply_done, 0);

        // Full load of stage 2, commit held off until tick
        send(16'hA102);
        chk("load_busy", busy, 1);
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444); send(16'h5555);
        chk("load_done_busy", busy, 0);
        send(16'hA200);
        chk("commit_ready", cfg_ready, 0);
        chk("commit_busy", busy, 1);
        idle(3);
        chk("notick_ready", cfg_ready, 0);
        chk("notick_stage2", stage(2), PASS);
        chk("notick_apply", apply_done, 0);
        tick();
        st2 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        chk("apply_stage2", stage(2), st2);
        chk("apply_pulse", apply_done, 1);
        chk("apply_ready", cfg_ready, 1);
        chk("apply_busy", busy, 0);
        chk("apply_stage0", stage(0), PASS);
        sample_tick = 1'b1;
        idle(1);
        sample_tick = 1'b0;
        chk("apply_pulse_end", apply_done, 0);

        // Header-looking word inside a load is just data
        send(16'hA100); send(16'h0001); send(16'h0002); send(16'hA200);
        chk("partial_busy", busy, 1);
        chk("partial_ready", cfg_ready, 1);
        send(16'h0004);
        chk("partial_stage0", stage(0), PASS);
        send(16'h0005);
        chk("partial_done_busy", busy, 0);
        // Tick coincident with the commit accept edge does not apply
        sample_tick = 1'b1;
        send(16'hA200);
        sample_tick = 1'b0;
        chk("cotick_apply", apply_done, 0);
        chk("cotick_ready", cfg_ready, 0);
        st0 = {16'h0005, 16'h0004, 16'hA200, 16'h0002, 16'h0001};
        chk("cotick_stage0", stage(0), PASS);
        tick();
        chk("apply2_stage0", stage(0), st0);
        chk("apply2_stage2", stage(2), st2);
        chk("apply2_pulse", apply_done, 1);

        // Out-of-range stage: five words skipped, then normal parsing resumes
        send(16'hA107);
        chk("skip_err", err, 1);
        chk("skip_busy", busy, 1);
        send(16'hA200); send(16'h0B02); send(16'h0B03); send(16'h0B04);
        chk("skip_busy4", busy, 1);
        chk("skip_ready4", cfg_ready, 1);
        send(16'h0B05);
        chk("skip_done_busy", busy, 0);
        send(16'hA103);
        chk("after_skip_busy", busy, 1);
        send(16'h7001); send(16'h7002); send(16'h7003); send(16'h7004); send(16'h7005);
        send(16'hA200);
        tick();
        st3 = {16'h7005, 16'h7004, 16'h7003, 16'h7002, 16'h7001};
        chk("skip_stage3", stage(3), st3);
        chk("skip_stage4", stage(4), PASS);
        chk("skip_err_sticky", err, 1);

        // Last load to a stage wins
        send(16'hA101); send(16'h1001); send(16'h1002); send(16'h1003); send(16'h1004); send(16'h1005);
        send(16'hA101); send(16'h2001); send(16'h2002); send(16'h2003); send(16'h2004); send(16'h2005);
        send(16'hA200);
        tick();
        chk("lastwins_stage1", stage(1), {16'h2005, 16'h2004, 16'h2003, 16'h2002, 16'h2001});

        // Bad sync and unknown opcode are dropped in IDLE
        send(16'h5100);
        chk("badsync_busy", busy, 0);
        chk("badsync_err", err, 1);
        send(16'hA300);
        chk("badop_busy", busy, 0);
        chk("badop_ready", cfg_ready, 1);
        send(16'hA200);
        tick();
        chk("empty_commit_pulse", apply_done, 1);
        chk("empty_commit_stage0", stage(0), st0);
        chk("empty_commit_stage3", stage(3), st3);

        // Reset while a commit is pending
        send(16'hA102); send(16'h9991); send(16'h9992); send(16'h9993); send(16'h9994); send(16'h9995);
        send(16'hA200);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_stage2", stage(2), PASS);
        chk("rstw_stage0", stage(0), PASS);
        chk("rstw_err", err, 0);
        chk("rstw_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstw_no_apply", apply_done, 0);
        chk("rstw_stage2_after", stage(2), PASS);
        chk("rstw_busy", busy, 0);

        // Reset mid-load: the partial stage never reaches the shadow bank
        send(16'hA101); send(16'h3001); send(16'h3002); send(16'h3003);
        #2 rst_n = 1'b0;
        #1;
        chk("rstl_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("rstl_ready", cfg_ready, 1);
        chk("rstl_apply", apply_done, 0);
        send(16'hA200);
        tick();
        chk("rstl_pulse", apply_done, 1);
        chk("rstl_stage1", stage(1), PASS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_coeff_loader.md
Name: eq_coeff_loader

Overview:
- Configuration-side writer for the equalizer's cascaded biquad IIR stages.
- Accepts a valid/ready word stream from the host/control bus, parses load and commit commands, and assembles per-stage coefficient sets into a shadow bank.
- On commit, copies the shadow bank to the active bank atomically on the next sample boundary. Every stage therefore switches coefficients on the same sample.
- The active bank drives the coeff_in_1..3 / coeff_out_1..2 ports of all filter stages.

Parameters:
- DATA_BIT_NUM, 16, coefficient and config word width.
- NUM_STAGES, 5, number of biquad stages served (max 16).
- UNITY, 16'h4000, reset value of each stage's coeff_in_1 (pass-through gain); all other coefficients reset to 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  host word valid.
- cfg_data  in  DATA_BIT_NUM  host word.
- cfg_ready  out  1  loader can accept a word.
- sample_tick  in  1  one-cycle strobe marking a sample boundary of the filter chain.
- coeff_bus  out  NUM_STAGES*5*DATA_BIT_NUM  active coefficients. Stage s occupies [s*80 +: 80]. Within a stage, lowest word first: coeff_in_1, coeff_in_2, coeff_in_3, coeff_out_1, coeff_out_2.
- busy  out  1  high in any state other than IDLE.
- apply_done  out  1  one-cycle pulse after an active-bank update.
- err  out  1  sticky protocol error flag; cleared only by reset.

Behaviour:
- Transfer: a word is accepted on a rising clk edge when cfg_valid && cfg_ready. cfg_data is sampled only on accept.
- Header word fields: [15:12] sync (must be 4'hA), [11:8] opcode (1 = LOAD, 2 = COMMIT), [7:4] reserved (ignored), [3:0] stage index.
- Reset values: cfg_ready=1, busy=0, apply_done=0, err=0, FSM=IDLE, word counter=0.
  - Active and shadow banks: coeff_in_1=UNITY for every stage, all other coefficients 0.
  - Staging registers: 0.
- FSM states: IDLE, LOAD, SKIP, WAIT_APPLY.
- IDLE:
  - Accepted header with LOAD and index < NUM_STAGES: latch index, clear counter, go to LOAD.
  - LOAD with index >= NUM_STAGES: set err, go to SKIP.
  - COMMIT: go to WAIT_APPLY.
  - Bad sync or unknown opcode: set err, stay in IDLE (word dropped).
- LOAD:
  - Each accepted word goes to staging[counter], counter increments.
  - On the 5th accepted word, all 5 words are written to the shadow bank for the latched stage in the same edge. Go to IDLE.
  - A partially loaded stage never reaches the shadow bank.
- SKIP: consume and discard 5 accepted words, then go to IDLE.
- WAIT_APPLY:
  - cfg_ready=0.
  - On the first edge with sample_tick=1, the entire shadow bank is copied to the active bank, apply_done is set to 1 (registered, high for exactly the next cycle), and the FSM goes to IDLE.
  - A sample_tick coincident with the COMMIT accept edge does not count.
  - A tick in the same cycle as apply_done is ignored.
- cfg_ready is combinational from state: 1 in IDLE, LOAD and SKIP; 0 in WAIT_APPLY.
- coeff_bus changes only at the apply edge (or at reset). It is never glitched mid-sample.
- LOAD then COMMIT: the stage loaded last is included. Multiple LOADs to the same stage before a COMMIT: the last one wins.
- COMMIT with no preceding LOAD: active becomes a copy of shadow, so coeff_bus values are unchanged, but apply_done still pulses.
- Reset mid-operation: rst_n low at any time returns every register to its reset value immediately. Active coefficients revert to pass-through.
- No arithmetic: coefficient words are stored and forwarded verbatim as signed DATA_BIT_NUM values.

Test Plan:
- Reset → coeff_bus stage0..4 = {0,0,0,0,16'h4000} (high→low word order); cfg_ready=1; busy=0; err=0.
- Send A102, 1111, 2222, 3333, 4444, 5555, then A200; hold sample_tick=0 → coeff_bus unchanged; cfg_ready=0. Pulse tick → next edge stage2 = 1111/2222/3333/4444/5555 (coeff_in_1..coeff_out_2); apply_done high 1 cycle; cfg_ready=1.
- Send A100, 0001, 0002, A200 (3-word partial load) → the "A200" is stored as the 3rd coefficient, still in LOAD; send 2 more words, then A200 + tick → stage0 = 0001, 0002, A200, w4, w5.
- Send A107 (index 7 ≥ 5) + 5 words → err=1; all 5 words discarded; the next header is parsed normally; err stays 1.
- Send 5100 (bad sync) → err=1, FSM stays IDLE, busy=0; send A200 + tick → apply_done pulses, coeff_bus unchanged.
- During WAIT_APPLY, or mid-LOAD after 3 words, drive rst_n=0 → coeff_bus returns to pass-through asynchronously; after release, cfg_ready=1 and no apply_done pulse.
